// File: rtl/rf_frontend_pkg.sv
// Shared definitions for the RF front end: NCO width defaults, NCO state
// encoding and maximal-length LFSR tap masks.
package rf_frontend_pkg;

    localparam int unsigned ACC_WIDTH_DEF   = 32;
    localparam int unsigned ANGLE_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDrain
    } nco_state_e;

    // Single tap at position n (taps numbered 1..width).
    function automatic logic [31:0] tap_bit(int unsigned n);
        return 32'h1 << (n - 1);
    endfunction

    // Fibonacci feedback masks giving maximal-length sequences for widths 2..32.
    function automatic logic [31:0] lfsr_taps(int unsigned width);
        case (width)
            2:  return tap_bit(2)  | tap_bit(1);
            3:  return tap_bit(3)  | tap_bit(2);
            4:  return tap_bit(4)  | tap_bit(3);
            5:  return tap_bit(5)  | tap_bit(3);
            6:  return tap_bit(6)  | tap_bit(5);
            7:  return tap_bit(7)  | tap_bit(6);
            8:  return tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
            9:  return tap_bit(9)  | tap_bit(5);
            10: return tap_bit(10) | tap_bit(7);
            11: return tap_bit(11) | tap_bit(9);
            12: return tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
            13: return tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
            14: return tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
            15: return tap_bit(15) | tap_bit(14);
            16: return tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17: return tap_bit(17) | tap_bit(14);
            18: return tap_bit(18) | tap_bit(11);
            19: return tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
            20: return tap_bit(20) | tap_bit(17);
            21: return tap_bit(21) | tap_bit(19);
            22: return tap_bit(22) | tap_bit(21);
            23: return tap_bit(23) | tap_bit(18);
            24: return tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25: return tap_bit(25) | tap_bit(22);
            26: return tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
            27: return tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
            28: return tap_bit(28) | tap_bit(25);
            29: return tap_bit(29) | tap_bit(27);
            30: return tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
            31: return tap_bit(31) | tap_bit(28);
            32: return tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/nco_lfsr.sv
// Maximal-length Fibonacci LFSR used as phase dither source.
// Seeds to all-ones on reset and steps once per cycle with en_i high.
module nco_lfsr
    import rf_frontend_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] lfsr_o
);

    localparam logic [31:0]      TapsFull = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] Taps     = TapsFull[WIDTH-1:0];

    logic [WIDTH-1:0] lfsr_q, lfsr_d;

    // Shift left, feeding the XOR of the tapped bits into bit 0.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & Taps)};
        end
    end

    // State register with synchronous all-ones seed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= '1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/nco_phase_gen.sv
// Phase-accumulator NCO front end producing the CORDIC angle stream over a
// valid/ready handshake. FTW updates are double-buffered and applied only at
// sample boundaries. Optional build macro PHASE_DITHER_EN adds LFSR dither
// below the truncation point (angle only; the accumulator is never dithered).
module nco_phase_gen
    import rf_frontend_pkg::*;
#(
    parameter int unsigned ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int unsigned ANGLE_WIDTH = ANGLE_WIDTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   run_i,
    input  logic [ACC_WIDTH-1:0]   ftw_i,
    input  logic                   ftw_load_i,
    input  logic [ANGLE_WIDTH-1:0] phase_offset_i,
    input  logic                   sync_clr_i,
    output logic [ANGLE_WIDTH-1:0] angle_o,
    output logic                   angle_valid_o,
    input  logic                   angle_ready_i,
    output logic                   ftw_pending_o,
    output logic                   wrap_o
);

    localparam int unsigned Shift = ACC_WIDTH - ANGLE_WIDTH;

    nco_state_e             state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   ftw_act_q, ftw_act_d;
    logic [ACC_WIDTH-1:0]   ftw_shd_q, ftw_shd_d;
    logic                   ftw_pending_q, ftw_pending_d;
    logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
    logic                   angle_valid_q, angle_valid_d;
    logic                   wrap_q, wrap_d;

    logic                   xfer;
    logic                   ftw_copy;
    logic [ACC_WIDTH:0]     sum_full;
    logic [ACC_WIDTH-1:0]   angle_src;
    logic [ANGLE_WIDTH-1:0] new_angle;

    assign xfer     = angle_valid_q && angle_ready_i;
    assign sum_full = {1'b0, acc_q} + {1'b0, ftw_act_q};
    // Shadow FTW is applied at a sample boundary, or at once while idle.
    assign ftw_copy = ftw_pending_q && ((state_q == StIdle) || xfer);

`ifdef PHASE_DITHER_EN
    localparam int unsigned DitherWidth = ACC_WIDTH - ANGLE_WIDTH;
    if (DitherWidth >= 2) begin : g_dither
        logic [DitherWidth-1:0] lfsr;
        nco_lfsr #(
            .WIDTH(DitherWidth)
        ) u_lfsr (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (xfer),
            .lfsr_o (lfsr)
        );
        assign angle_src = acc_d + {{ANGLE_WIDTH{1'b0}}, lfsr};
    end else begin : g_no_dither
        assign angle_src = acc_d;
    end
`else
    assign angle_src = acc_d;
`endif

    // Angle candidate: truncated post-update accumulator plus offset.
    assign new_angle = ANGLE_WIDTH'(angle_src >> Shift) + phase_offset_i;

    // Accumulator, FTW double-buffer and wrap detection.
    always_comb begin
        acc_d = acc_q;
        if (xfer) begin
            acc_d = sum_full[ACC_WIDTH-1:0];
        end
        if (sync_clr_i) begin
            acc_d = '0;
        end
        wrap_d        = xfer && sum_full[ACC_WIDTH] && !sync_clr_i;
        ftw_act_d     = ftw_copy ? ftw_shd_q : ftw_act_q;
        ftw_shd_d     = ftw_load_i ? ftw_i : ftw_shd_q;
        // A load in the copy cycle wins, so the new word stays pending.
        ftw_pending_d = ftw_load_i || (ftw_pending_q && !ftw_copy);
    end

    // Handshake state machine and angle register.
    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        unique case (state_q)
            StIdle: begin
                if (run_i) begin
                    angle_d = new_angle;
                    state_d = StActive;
                end
            end
            StActive: begin
                if (xfer) begin
                    if (run_i) begin
                        angle_d = new_angle;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (!run_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (xfer) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        angle_valid_d = (state_d != StIdle);
    end

    // All state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            acc_q         <= '0;
            ftw_act_q     <= '0;
            ftw_shd_q     <= '0;
            ftw_pending_q <= 1'b0;
            angle_q       <= '0;
            angle_valid_q <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            ftw_act_q     <= ftw_act_d;
            ftw_shd_q     <= ftw_shd_d;
            ftw_pending_q <= ftw_pending_d;
            angle_q       <= angle_d;
            angle_valid_q <= angle_valid_d;
            wrap_q        <= wrap_d;
        end
    end

    assign angle_o       = angle_q;
    assign angle_valid_o = angle_valid_q;
    assign ftw_pending_o = ftw_pending_q;
    assign wrap_o        = wrap_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
// Self-checking bench for nco_phase_gen: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_nco_phase_gen;

    localparam int unsigned AW = 32;
    localparam int unsigned GW = 16;

    logic          clk = 1'b0;
    logic          rst, run, ftw_load, sync_clr, angle_ready;
    logic [AW-1:0] ftw;
    logic [GW-1:0] phase_offset;
    logic [GW-1:0] angle;
    logic          angle_valid, ftw_pending, wrap;

    int errors = 0;
    int checks = 0;

    nco_phase_gen #(
        .ACC_WIDTH   (AW),
        .ANGLE_WIDTH (GW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .run_i          (run),
        .ftw_i          (ftw),
        .ftw_load_i     (ftw_load),
        .phase_offset_i (phase_offset),
        .sync_clr_i     (sync_clr),
        .angle_o        (angle),
        .angle_valid_o  (angle_valid),
        .angle_ready_i  (angle_ready),
        .ftw_pending_o  (ftw_pending),
        .wrap_o         (wrap)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 = idle, 1 = active, 2 = drain.
    logic [AW-1:0] m_acc, m_act, m_shd;
    logic          m_pend, m_wrap;
    logic [GW-1:0] m_angle;
    int            m_mode;

    always @(posedge clk) begin
        logic          x, cp;
        logic [AW:0]   s;
        logic [AW-1:0] na;
        if (rst) begin
            m_acc = 0; m_act = 0; m_shd = 0; m_pend = 0; m_wrap = 0;
            m_angle = 0; m_mode = 0;
        end else begin
            x  = (m_mode != 0) && angle_ready;
            s  = {1'b0, m_acc} + {1'b0, m_act};
            na = m_acc;
            if (x) na = s[AW-1:0];
            if (sync_clr) na = 0;
            m_wrap = x && s[AW] && !sync_clr;
            cp = m_pend && (m_mode == 0 || x);
            if (cp) m_act = m_shd;
            if (ftw_load) m_shd = ftw;
            m_pend = ftw_load ? 1'b1 : (cp ? 1'b0 : m_pend);
            if (m_mode == 0) begin
                if (run) begin
                    m_angle = GW'(na / (64'd1 << (AW - GW))) + phase_offset;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (x) begin
                    if (run) m_angle = GW'(na / (64'd1 << (AW - GW))) + phase_offset;
                    else m_mode = 0;
                end else if (!run) begin
                    m_mode = 2;
                end
            end else begin
                if (x) m_mode = 0;
            end
            m_acc = na;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Dither may raise the truncated angle by at most one LSB.
    task automatic chk_angle(input string name, input logic [GW-1:0] got,
                             input logic [GW-1:0] exp);
        logic [GW-1:0] d;
        logic          ok;
        d = got - exp;
`ifdef PHASE_DITHER_EN
        ok = (d <= 1) && !$isunknown(got);
`else
        ok = (d == 0) && !$isunknown(got);
`endif
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic cyc();
        @(negedge clk);
        chk("model_valid", 32'(angle_valid), 32'(m_mode != 0));
        chk("model_wrap", 32'(wrap), 32'(m_wrap));
        chk("model_pending", 32'(ftw_pending), 32'(m_pend));
        chk_angle("model_angle", angle, m_angle);
    endtask

    initial begin
        rst = 1; run = 0; ftw_load = 0; sync_clr = 0; angle_ready = 0;
        ftw = 0; phase_offset = 0;
        cyc(); cyc();
        chk("reset_valid", 32'(angle_valid), 0);
        chk("reset_angle", 32'(angle), 0);
        chk("reset_wrap", 32'(wrap), 0);
        chk("reset_pending", 32'(ftw_pending), 0);

        // Phase ramp.
        rst = 0; ftw = 32'h0100_0000; ftw_load = 1;
        cyc();
        ftw_load = 0;
        chk("ramp_pending_idle", 32'(ftw_pending), 1);
        run = 1; angle_ready = 1;
        cyc();
        chk("ramp_first_valid", 32'(angle_valid), 1);
        chk_angle("ramp_a0", angle, 16'h0000);
        chk("ramp_copied", 32'(ftw_pending), 0);
        cyc(); chk_angle("ramp_a1", angle, 16'h0100);
        cyc(); chk_angle("ramp_a2", angle, 16'h0200);
        for (int i = 3; i <= 255; i++) begin
            cyc();
            chk_angle("ramp_an", angle, GW'(i * 256));
            chk("ramp_nowrap", 32'(wrap), 0);
        end
        cyc();
        chk("ramp_wrap256", 32'(wrap), 1);
        chk_angle("ramp_a256", angle, 16'h0000);
        cyc();
        chk("ramp_wrap_pulse", 32'(wrap), 0);
        chk_angle("ramp_a257", angle, 16'h0100);

        // Backpressure.
        angle_ready = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_angle("bp_hold", angle, 16'h0100);
            chk("bp_valid", 32'(angle_valid), 1);
        end
        angle_ready = 1;
        cyc(); chk_angle("bp_resume", angle, 16'h0200);

        // FTW switch mid-stream.
        angle_ready = 0; ftw = 32'h0400_0000; ftw_load = 1;
        cyc();
        ftw_load = 0;
        chk("sw_pending", 32'(ftw_pending), 1);
        cyc();
        chk("sw_pending_hold", 32'(ftw_pending), 1);
        angle_ready = 1;
        cyc();
        chk_angle("sw_old_step", angle, 16'h0300);
        chk("sw_cleared", 32'(ftw_pending), 0);
        cyc();
        chk_angle("sw_new_step", angle, 16'h0700);

        // sync_clr while stalled, then with a transfer.
        angle_ready = 0; sync_clr = 1; phase_offset = 16'h1234;
        cyc(); chk_angle("clr_held", angle, 16'h0700);
        cyc(); chk_angle("clr_held2", angle, 16'h0700);
        angle_ready = 1;
        cyc();
        chk_angle("clr_offset", angle, 16'h1234);
        chk("clr_nowrap", 32'(wrap), 0);
        sync_clr = 0;

        // run drop under stall: drain, ignore run reassert, idle after one transfer.
        angle_ready = 0; run = 0;
        cyc(); chk("drain_valid", 32'(angle_valid), 1);
        run = 1;
        cyc(); chk("drain_ignore_run", 32'(angle_valid), 1);
        chk_angle("drain_held", angle, 16'h1234);
        run = 0; angle_ready = 1;
        cyc(); chk("drain_to_idle", 32'(angle_valid), 0);
        cyc(); chk("idle_stays", 32'(angle_valid), 0);

        // Reset mid-stream with a pending FTW.
        run = 1;
        cyc(); chk("restart_valid", 32'(angle_valid), 1);
        angle_ready = 0; ftw = 32'h5; ftw_load = 1;
        cyc();
        ftw_load = 0;
        chk("pre_rst_pending", 32'(ftw_pending), 1);
        rst = 1; run = 0;
        cyc();
        chk("rst_valid", 32'(angle_valid), 0);
        chk("rst_angle", 32'(angle), 0);
        chk("rst_pending", 32'(ftw_pending), 0);
        chk("rst_wrap", 32'(wrap), 0);

        // Offset and wrap.
        rst = 0; ftw = 32'hFFFF_0000; ftw_load = 1; phase_offset = 16'h8000; angle_ready = 1;
        cyc();
        ftw_load = 0; run = 1;
        cyc(); chk_angle("ofs_a0", angle, 16'h8000);
        cyc(); chk_angle("ofs_a1", angle, 16'h7FFF);
        chk("ofs_wrap1", 32'(wrap), 0);
        cyc(); chk_angle("ofs_a2", angle, 16'h7FFE);
        chk("ofs_wrap2", 32'(wrap), 1);
        cyc(); chk("ofs_wrap3", 32'(wrap), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            run          = ($urandom_range(0, 9) != 0);
            angle_ready  = ($urandom_range(0, 2) != 0);
            ftw_load     = ($urandom_range(0, 19) == 0);
            ftw          = ($urandom_range(0, 3) == 0) ? ($urandom | 32'hF000_0000) : $urandom;
            sync_clr     = ($urandom_range(0, 49) == 0);
            phase_offset = GW'($urandom);
            rst          = ($urandom_range(0, 499) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nco_phase_gen.md
# nco_phase_gen

Phase-accumulator NCO front end that generates the angle stream consumed by the CORDIC sine/cosine stage. Each accepted sample advances a 32-bit accumulator by a frequency tuning word (FTW) and presents a truncated, offset angle through a valid/ready handshake. The CORDIC ready output drives this block's ready input, and its enable input is driven from this block's valid output. FTW changes are double-buffered and take effect only at sample boundaries.

## Interface
- ACC_WIDTH, 32, phase accumulator width
- ANGLE_WIDTH, 16, output angle width (ANGLE_WIDTH ≤ ACC_WIDTH)
- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous and active-high
- run  in  1  level; 1 = generate angles
- ftw  in  ACC_WIDTH  frequency tuning word (unsigned)
- ftw_load  in  1  pulse; captures ftw into the shadow register
- phase_offset  in  ANGLE_WIDTH  phase offset added after truncation, sampled at each angle load
- sync_clr  in  1  pulse; clears the accumulator to 0
- angle  out  ANGLE_WIDTH  angle to the CORDIC; 0 to 2π maps to 0 to 2^ANGLE_WIDTH
- angle_valid  out  1  angle is presented
- angle_ready  in  1  downstream can accept
- ftw_pending  out  1  the shadow FTW has not yet been applied
- wrap  out  1  one-cycle pulse when an accepted increment carries out of the accumulator

## Operation
- A transfer occurs on a clock edge where angle_valid && angle_ready.
- Registers:
  - acc: the accumulator.
  - ftw_act: the FTW in use.
  - ftw_shd: the shadow FTW.
  - Output register: holds angle.
- Angle formula: angle = acc[ACC_WIDTH-1 -: ANGLE_WIDTH] + phase_offset, computed mod 2^ANGLE_WIDTH.
- The next angle is computed from the post-increment accumulator value.
- States:
  - IDLE: angle_valid=0. If run=1, load angle from the current acc and go to ACTIVE.
  - ACTIVE: angle_valid=1.
    - On a transfer: acc ← acc + ftw_act, the angle is reloaded from the new acc, and the state stays in ACTIVE. Back-to-back transfers are allowed, with no bubble.
    - If run=0 and there is no transfer, go to DRAIN.
    - If run=0 and a transfer occurs, go to IDLE. acc still increments; the angle is not reloaded.
  - DRAIN: angle_valid=1 and angle held. On a transfer: acc increments and the state goes to IDLE. A run reassertion in DRAIN is ignored until IDLE is reached.
- No retraction: while angle_valid=1 and angle_ready=0, angle stays bit-stable.
- FTW update:
  - ftw_load writes ftw_shd and sets ftw_pending.
  - The shadow is copied into ftw_act on the next transfer, or immediately if the state is IDLE. This clears ftw_pending.
  - The increment on the copy cycle uses the old ftw_act.
  - A second ftw_load while pending overwrites ftw_shd.
  - If ftw_load occurs in the same cycle as a copy, the new value stays pending.
- sync_clr:
  - acc ← 0, overriding any same-cycle increment; the wrap pulse is suppressed.
  - A held angle is not altered.
  - The next loaded angle is phase_offset.
- wrap: registered. High for one cycle after a transfer whose add carried out of bit ACC_WIDTH-1.
- Arithmetic: unsigned, modulo 2^ACC_WIDTH. Overflow is only reported by wrap.

## Timing
- Reset values: angle=0, angle_valid=0, wrap=0, ftw_pending=0; acc=0, ftw_act=0, ftw_shd=0; state=IDLE.
- Reset mid-operation clears all state on the next edge. angle_valid drops regardless of the handshake.
- run sampled high in IDLE at edge k gives angle_valid=1 after edge k (1-cycle latency).
- Throughput: 1 angle per cycle while angle_ready=1. With the CORDIC, it is gated by ready roughly every ITERATIONS+2 cycles.
- A new FTW affects the angle presented after the second transfer following ftw_load while in ACTIVE.

## Configuration
- PHASE_DITHER_EN defined:
  - A maximal-length LFSR of width ACC_WIDTH-ANGLE_WIDTH (seed all-ones) is added to the bits below the truncation point before truncation.
  - The LFSR advances once per transfer.
  - Dither affects only the angle, never acc.
  - If ACC_WIDTH-ANGLE_WIDTH < 2, dither is forced off.
- Undefined: pure truncation; no LFSR logic.

## Structure
- Shared package rf_frontend_pkg: the ACC_WIDTH/ANGLE_WIDTH defaults, the nco state enum (IDLE, ACTIVE, DRAIN), and the LFSR tap constants.
- One sub-module, nco_lfsr (parameterised width, enable, synchronous active-high reset). It is instantiated only under PHASE_DITHER_EN.

## Test plan
- Phase ramp: rst, then ftw=0x0100_0000 with ftw_load, phase_offset=0, run=1, angle_ready=1 → angles 0x0000, 0x0100, 0x0200, …; wrap pulses once after the 256th transfer.
- Backpressure: ready low for 10 cycles in ACTIVE → angle is stable and valid stays high. The first transfer after ready returns resumes with the next expected value, with no skipped samples.
- FTW switch: ftw 0x0100_0000 → 0x0400_0000 loaded mid-stream → ftw_pending is 1 until the next transfer. The following angle steps are 0x0100, then 0x0400, per the copy-cycle rule.
- Offset and wrap: ftw=0xFFFF_0000, phase_offset=0x8000 → angle sequence 0x8000, 0x7FFF, 0x7FFE; wrap=1 from the second transfer onward.
- sync_clr and run drop: sync_clr asserted while valid and not ready → the held angle is unchanged; after the transfer, the angle equals phase_offset. run dropped with ready=0 → DRAIN, valid held, then IDLE after a single transfer.
- Reset mid-stream: rst asserted in ACTIVE with a pending FTW → all outputs are 0 the next cycle. Under PHASE_DITHER_EN, the ramp test stays within ±1 LSB of the ideal angle.
